// File: rtl/dsm_filter_pkg.sv
// dsm_filter_pkg: shared widths and ratios for the delta-sigma decimation chain
package dsm_filter_pkg;
    localparam int IN_W       = 2;
    localparam int N          = 5;
    localparam int DECIM      = 64;
    localparam int LOG2_DECIM = 6;
    localparam int OUT_W      = 33;
    localparam int REG_W      = IN_W + N * LOG2_DECIM;
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one registered CIC comb (y = x - x_prev), advanced only by x_valid
module cic_comb_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic         x_valid,
    output logic [W-1:0] y,
    output logic         y_valid
);
    logic [W-1:0] d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                y <= x - d;
                d <= x;
            end
        end
    end
endmodule

// File: rtl/cic5_decim.sv
// cic5_decim: five-stage CIC decimator (modular REG_W arithmetic) feeding the first half-band
module cic5_decim
    import dsm_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             valid_in,
    output logic [OUT_W-1:0] out,
    output logic             valid_out
);
    logic [REG_W-1:0]      integ [N];
    logic [LOG2_DECIM-1:0] cnt;
    logic [REG_W-1:0]      c [N+1];
    logic                  v [N+1];
    logic [REG_W-1:0]      in_ext;
    logic                  strobe;

    assign in_ext = {{(REG_W-IN_W){in[IN_W-1]}}, in};
    assign strobe = valid_in && (cnt == LOG2_DECIM'(DECIM - 1));

    // the counter wraps naturally because DECIM is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) integ[i] <= '0;
            cnt  <= '0;
            c[0] <= '0;
            v[0] <= 1'b0;
        end else begin
            if (valid_in) begin
                integ[0] <= integ[0] + in_ext;
                for (int i = 1; i < N; i++) integ[i] <= integ[i] + integ[i-1];
                cnt <= cnt + 1'b1;
            end
            v[0] <= strobe;
            if (strobe) c[0] <= integ[N-1];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_comb
        cic_comb_stage #(.W(REG_W)) u_comb (
            .clk     (clk),
            .rst     (rst),
            .x       (c[g]),
            .x_valid (v[g]),
            .y       (c[g+1]),
            .y_valid (v[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out       <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v[N];
            if (v[N]) out <= {{(OUT_W-REG_W){c[N][REG_W-1]}}, c[N]};
        end
    end
endmodule

// File: tb/tb_cic5_decim.sv
// tb_cic5_decim: directed DC/impulse/gap/reset vectors with hand-computed expectations
module tb_cic5_decim;
    import dsm_filter_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IN_W-1:0]  in = '0;
    logic             valid_in = 1'b0;
    logic [OUT_W-1:0] out;
    logic             valid_out;

    int pass_n = 0;
    int total_n = 0;
    int cyc = 0;
    int acc[$];
    int vo[$];
    logic [OUT_W-1:0] outs[$];
    logic [OUT_W-1:0] ref_out[$];

    typedef struct {
        logic [1:0]       x;
        bit               gaps;
        logic [OUT_W-1:0] steady;
    } vec_t;

    vec_t tbl[5];

    cic5_decim dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .valid_in  (valid_in),
        .out       (out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input logic r, input logic v, input logic [1:0] x);
        rst = r;
        valid_in = v;
        in = x;
        @(posedge clk);
        #1;
        cyc++;
        if (r && v) acc.push_back(cyc);
        if (valid_out) begin
            outs.push_back(out);
            vo.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 2'b01);
            check("reset_out", 64'(out), 64'd0);
            check("reset_valid", 64'(valid_out), 64'd0);
        end
        acc.delete();
        vo.delete();
        outs.delete();
    endtask

    // impulse mode feeds +1 as the first accepted sample, then zeros
    task automatic run(input logic [1:0] x, input bit gaps, input bit imp, input int nout);
        for (int k = 0; k < 5000 && outs.size() < nout; k++)
            tick(1'b1, gaps ? 1'($urandom_range(0, 1)) : 1'b1,
                 imp ? (acc.size() == 0 ? 2'b01 : 2'b00) : x);
        check("out_count", 64'(outs.size() >= nout), 64'd1);
        for (int m = 0; m < nout && m < outs.size(); m++)
            check("latency", 64'(vo[m]), 64'(acc[64*m+63] + 6));
    endtask

    task automatic idle_hold();
        int n;
        logic [OUT_W-1:0] last;
        n = outs.size();
        last = out;
        for (int k = 0; k < 100; k++) tick(1'b1, 1'b0, 2'b01);
        check("idle_no_output", 64'(outs.size()), 64'(n));
        check("idle_out_held", 64'(out), 64'(last));
    endtask

    initial begin
        longint sum;
        tbl[0] = '{2'b01, 1'b0, 33'h0_4000_0000};
        tbl[1] = '{2'b10, 1'b0, 33'h1_8000_0000};
        tbl[2] = '{2'b01, 1'b1, 33'h0_4000_0000};
        tbl[3] = '{2'b11, 1'b0, 33'h1_C000_0000};
        tbl[4] = '{2'b00, 1'b1, 33'h0_0000_0000};

        do_reset();
        for (int t = 0; t < 5; t++) begin
            do_reset();
            run(tbl[t].x, tbl[t].gaps, 1'b0, 10);
            for (int m = 6; m < 10; m++) check("dc_steady", 64'(outs[m]), 64'(tbl[t].steady));
            if (tbl[t].x == 2'b01 && !tbl[t].gaps) begin
                ref_out = outs;
                for (int m = 1; m < 7; m++)
                    check("dc_monotonic", 64'($signed(outs[m]) >= $signed(outs[m-1])), 64'd1);
            end
            if (tbl[t].x == 2'b01 && tbl[t].gaps)
                for (int m = 0; m < 10; m++) check("gaps_match", 64'(outs[m]), 64'(ref_out[m]));
            idle_hold();
        end

        do_reset();
        run(2'b00, 1'b0, 1'b1, 12);
        sum = 0;
        for (int m = 0; m < 12; m++) sum += longint'($signed(outs[m]));
        check("impulse_sum", 64'(sum), 64'd16777216);
        for (int m = 7; m < 12; m++) check("impulse_tail", 64'(outs[m]), 64'd0);

        do_reset();
        for (int k = 0; k < 64; k++) tick(1'b1, 1'b1, 2'b01);
        tick(1'b0, 1'b1, 2'b01);
        acc.delete();
        vo.delete();
        outs.delete();
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 2'b01);
        check("abort_no_output", 64'(outs.size()), 64'd0);
        run(2'b01, 1'b0, 1'b0, 2);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
